fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences each fetch through the instruction-memory request/response handshake. It presents each fetched instruction to decode with a valid/ready handshake. On consumption it loads the next PC: PC+4, or the redirect target produced by the core's next-PC selection logic (branch, JAL, JALR). It discards any fetch made stale by a redirect.

---
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch controller. Owns the program counter, runs
//            each fetch through the imem request/grant/response handshake,
//            holds the fetched word for decode under valid/ready and loads
//            the next PC (PC+4 or a redirect target) on consumption. Any
//            response made stale by a redirect is swallowed.
// Ports    : clk, rst_n           - clock, synchronous active-low reset
//            imem_req/addr        - fetch request and its address (== pc)
//            imem_gnt             - memory accepted the request
//            imem_rvalid/rdata    - fetch response
//            inst_valid/inst/pc   - held instruction presented to decode
//            inst_ready           - decode consumes the held instruction
//            redirect/redirect_pc - next-PC override, sampled every cycle
//            fetch_cnt            - number of consumed instructions
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_inst_pc;
    logic [31:0] w_inst_pc_nxt;
    logic [31:0] r_fetch_cnt;
    logic [31:0] w_fetch_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst      <= 32'd0;
            r_inst_pc   <= 32'd0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_inst      <= w_inst_nxt;
            r_inst_pc   <= w_inst_pc_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_nxt      = r_drop;
        w_inst_nxt      = r_inst;
        w_inst_pc_nxt   = r_inst_pc;
        w_fetch_cnt_nxt = r_fetch_cnt;

        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end

            S_REQ: begin
                // The address may follow a redirect freely until granted.
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end
                if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                    // Granted with the old address: its response is stale.
                    if (redirect) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end
                if (imem_rvalid) begin
                    if (r_drop || redirect) begin
                        // Exactly one response is swallowed per stale fetch.
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_inst_nxt    = imem_rdata;
                        w_inst_pc_nxt = r_pc;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (redirect) begin
                    w_drop_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                if (inst_ready) begin
                    w_fetch_cnt_nxt = r_fetch_cnt + 32'd1;
                    w_pc_nxt        = redirect ? redirect_pc : (r_pc + c_PC_STEP);
                    w_state_nxt     = S_REQ;
                end else if (redirect) begin
                    // Flush the unconsumed instruction without counting it.
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign inst_valid = (r_state == S_HOLD);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fetch_cnt  = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer: directed vector table,
//            a hand-written reset-during-fetch sequence and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;

    fetch_sequencer #(.RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, take the edge, settle for sampling.
    task automatic step(input logic rst, input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rr, input logic [31:0] rp);
        rst_n       = rst;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        inst_ready  = rdy;
        redirect    = rr;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic rr, input logic [31:0] rp, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei, input logic [31:0] eip,
                       input logic [31:0] ec);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redir = rr; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = eip; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        m_idle, m_req, m_out, m_live, m_hold;
    logic [31:0] m_pc, m_cnt, m_out_addr, m_inst, m_inst_pc;
    int          m_delay;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_req = 1'b0; m_out = 1'b0; m_live = 1'b0; m_hold = 1'b0;
        m_pc = c_RESET_PC; m_cnt = 32'd0; m_out_addr = 32'd0; m_delay = 0;
        m_inst = 32'd0; m_inst_pc = 32'd0;
    endtask

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic model_update(input logic rst, input logic g, input logic rv, input logic rdy,
                                input logic rr, input logic [31:0] rp);
        if (!rst) begin
            model_reset();
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
        end else if (m_req) begin
            if (g) begin
                m_req      = 1'b0;
                m_out      = 1'b1;
                m_live     = !rr;
                m_out_addr = m_pc;
                m_delay    = int'($urandom_range(0, 2));
            end
            if (rr) m_pc = rp;
        end else if (m_out) begin
            if (rv) begin
                m_out = 1'b0;
                if (m_live && !rr) begin
                    m_hold    = 1'b1;
                    m_inst    = mem_word(m_out_addr);
                    m_inst_pc = m_out_addr;
                end else begin
                    m_req = 1'b1;
                end
            end else if (rr) begin
                m_live = 1'b0;
            end
            if (rr) m_pc = rp;
        end else if (m_hold) begin
            if (rdy) begin
                m_cnt  = m_cnt + 32'd1;
                m_hold = 1'b0;
                m_req  = 1'b1;
                m_pc   = rr ? rp : m_pc + 32'd4;
            end else if (rr) begin
                m_hold = 1'b0;
                m_req  = 1'b1;
                m_pc   = rp;
            end
        end
    endtask

    initial begin
        logic        g, rv, rdy, rr, rs;
        logic [31:0] rd, rp;

        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr",  imem_addr, c_RESET_PC);
        chk("rst_cnt",   fetch_cnt, 32'd0);
        chk("rst_inst",  inst,      32'd0);
        chk("rst_ipc",   inst_pc,   32'd0);

        // g  rv rdata          rdy rr rpc             req addr          v inst           ipc            cnt
        add(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h100,       0, 32'h0,        32'h0,         0);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h100,       0, 32'h0,        32'h0,         0);
        add(0, 1, 32'h1111_0000,0, 0, 32'h0,          0, 32'h100,       1, 32'h1111_0000,32'h100,       0);
        add(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h104,       0, 32'h0,        32'h0,         1);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h104,       0, 32'h0,        32'h0,         1);
        add(0, 1, 32'h2222_0000,0, 0, 32'h0,          0, 32'h104,       1, 32'h2222_0000,32'h104,       1);
        add(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h108,       0, 32'h0,        32'h0,         2);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h108,       0, 32'h0,        32'h0,         2);
        add(0, 1, 32'h3333_0000,0, 0, 32'h0,          0, 32'h108,       1, 32'h3333_0000,32'h108,       2);
        add(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h10C,       0, 32'h0,        32'h0,         3);
        add(0, 0, 32'h0,        0, 1, 32'h200,        1, 32'h200,       0, 32'h0,        32'h0,         3);
        add(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h200,       0, 32'h0,        32'h0,         3);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h200,       0, 32'h0,        32'h0,         3);
        add(0, 1, 32'h4444_0000,0, 0, 32'h0,          0, 32'h200,       1, 32'h4444_0000,32'h200,       3);
        add(0, 0, 32'h0,        1, 1, 32'h80,         1, 32'h80,        0, 32'h0,        32'h0,         4);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h80,        0, 32'h0,        32'h0,         4);
        add(0, 0, 32'h0,        0, 1, 32'h40,         0, 32'h40,        0, 32'h0,        32'h0,         4);
        add(0, 0, 32'h0,        0, 0, 32'h0,          0, 32'h40,        0, 32'h0,        32'h0,         4);
        add(0, 1, 32'hDEAD_BEEF,0, 0, 32'h0,          1, 32'h40,        0, 32'h0,        32'h0,         4);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h40,        0, 32'h0,        32'h0,         4);
        add(0, 1, 32'h5555_0000,0, 0, 32'h0,          0, 32'h40,        1, 32'h5555_0000,32'h40,        4);
        add(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h44,        0, 32'h0,        32'h0,         5);
        add(1, 0, 32'h0,        0, 1, 32'h40,         0, 32'h40,        0, 32'h0,        32'h0,         5);
        add(0, 1, 32'h6666_0000,0, 0, 32'h0,          1, 32'h40,        0, 32'h0,        32'h0,         5);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h40,        0, 32'h0,        32'h0,         5);
        add(0, 1, 32'h7777_0000,0, 0, 32'h0,          0, 32'h40,        1, 32'h7777_0000,32'h40,        5);
        for (int i = 0; i < 5; i++)
            add(0, 0, 32'h0,    0, 0, 32'h0,          0, 32'h40,        1, 32'h7777_0000,32'h40,        5);
        add(0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,         5);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,         5);
        add(0, 1, 32'h8888_0000,0, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'h8888_0000,32'hFFFF_FFFC, 5);
        add(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'h0,         6);
        add(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,         6);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b1, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready,
                 vecs[i].redir, vecs[i].rpc);
            chk($sformatf("vec%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].e_req});
            chk($sformatf("vec%0d_addr", i),  imem_addr,           vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_cnt", i),   fetch_cnt,           vecs[i].e_cnt);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_inst", i), inst,    vecs[i].e_inst);
                chk($sformatf("vec%0d_ipc", i),  inst_pc, vecs[i].e_ipc);
            end
        end

        // Reset while a fetch is outstanding, then a stray response.
        step(1'b0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("wrst_req",   {31'd0, imem_req},   32'd0);
        chk("wrst_valid", {31'd0, inst_valid}, 32'd0);
        chk("wrst_addr",  imem_addr, c_RESET_PC);
        chk("wrst_cnt",   fetch_cnt, 32'd0);
        step(1'b1, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h0);
        chk("stray1_req",   {31'd0, imem_req},   32'd1);
        chk("stray1_valid", {31'd0, inst_valid}, 32'd0);
        chk("stray1_addr",  imem_addr, c_RESET_PC);
        step(1'b1, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h0);
        chk("stray2_req",   {31'd0, imem_req},   32'd1);
        chk("stray2_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1, 0, 32'h0, 0, 0, 32'h0);
        chk("restart_req",  {31'd0, imem_req},   32'd0);
        step(1'b1, 0, 1, 32'h9999_0000, 0, 0, 32'h0);
        chk("restart_valid", {31'd0, inst_valid}, 32'd1);
        chk("restart_inst",  inst,    32'h9999_0000);
        chk("restart_ipc",   inst_pc, c_RESET_PC);

        // Randomized run against the reference model.
        step(1'b0, 0, 0, 32'h0, 0, 0, 32'h0);
        model_reset();
        for (int c = 0; c < 800; c++) begin
            rs  = ($urandom % 100) != 0;
            g   = $urandom_range(0, 1) == 1;
            rdy = ($urandom % 3) != 0;
            rr  = ($urandom % 6) == 0;
            rp  = (($urandom % 4) == 0) ? 32'hFFFF_FFFC : $urandom;
            rv  = 1'b0;
            rd  = $urandom;
            if (m_out) begin
                if (m_delay == 0) begin
                    rv = 1'b1;
                    rd = mem_word(m_out_addr);
                end else begin
                    m_delay--;
                end
            end
            step(rs, g, rv, rd, rdy, rr, rp);
            model_update(rs, g, rv, rdy, rr, rp);
            chk($sformatf("rnd%0d_req", c),   {31'd0, imem_req},   {31'd0, m_req});
            chk($sformatf("rnd%0d_addr", c),  imem_addr,           m_pc);
            chk($sformatf("rnd%0d_valid", c), {31'd0, inst_valid}, {31'd0, m_hold});
            chk($sformatf("rnd%0d_cnt", c),   fetch_cnt,           m_cnt);
            if (m_hold) begin
                chk($sformatf("rnd%0d_inst", c), inst,    m_inst);
                chk($sformatf("rnd%0d_ipc", c),  inst_pc, m_inst_pc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
